// File: rtl/uart_rx_writer.sv
// 8N1 UART receiver: synchronises rx_pin, samples each bit at mid-bit and
// pushes good bytes into a downstream FIFO, flagging framing errors and overruns.
module uart_rx_writer #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  input  logic       full,
  output logic       fifo_write_req,
  output logic [7:0] fifo_write_data,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic             sync1_q;
  logic             rx_s_q;
  logic             rx_d_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             wr_q, wr_d;
  logic [7:0]       data_q, data_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;

  // Two-flop synchroniser plus one delay flop for falling-edge detection; idle-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      rx_s_q  <= sync1_q;
      rx_d_q  <= rx_s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    wr_d    = 1'b0;
    data_d  = data_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_d_q && !rx_s_q) state_d = S_START;
      end

      // A start bit that is high again at mid-bit was only a glitch.
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end

      // Leaving at mid-stop gives half a bit of slack to catch a back-to-back start edge.
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
            if (full) begin
              ovr_d = 1'b1;
            end else begin
              wr_d   = 1'b1;
              data_d = shift_q;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end

      // Hold off until the line returns high so a break cannot re-trigger.
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign fifo_write_req  = wr_q;
  assign fifo_write_data = data_q;
  assign frame_err       = ferr_q;
  assign overrun         = ovr_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_uart_rx_writer.sv
// Self-checking bench for uart_rx_writer: drives 8N1 frames on rx_pin and compares
// the observed strobes/pulses against an event list predicted from frame timing.
module tb_uart_rx_writer;

  localparam int unsigned C = 16;
  // Pin fall to t0 is 3 cycles, start sample is t0 + C/2, stop sample 9 bits later;
  // the registered result is visible in the cycle that the stop-sample edge opens.
  localparam int LAT = 3 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pin;
  logic       full;
  logic       fifo_write_req;
  logic [7:0] fifo_write_data;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_writer #(.CLKS_PER_BIT(C)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_pin         (rx_pin),
    .full           (full),
    .fifo_write_req (fifo_write_req),
    .fifo_write_data(fifo_write_data),
    .frame_err      (frame_err),
    .overrun        (overrun),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // kind: 0 = write, 1 = frame_err, 2 = overrun; n = number of flags high together
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
    int         n;
  } ev_t;

  ev_t        obs[$];
  ev_t        exp_q[$];
  ev_t        mon_e;
  logic [7:0] last_wr;

  always @(negedge clk) begin
    if (!rst && (fifo_write_req || frame_err || overrun)) begin
      mon_e.kind = fifo_write_req ? 0 : (frame_err ? 1 : 2);
      mon_e.data = fifo_write_data;
      mon_e.cyc  = cyc;
      mon_e.n    = int'(fifo_write_req) + int'(frame_err) + int'(overrun);
      obs.push_back(mon_e);
    end
  end

  task automatic idle(input int n);
    rx_pin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is positioned 1 time unit after a rising edge; f is the cycle of the start fall.
  task automatic send(input logic [7:0] d, input logic stop, output int f);
    logic [9:0] b;
    b = {stop, d, 1'b0};
    f = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_pin = b[i];
      repeat (C) @(posedge clk);
      #1;
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop, input logic fl, input int f);
    ev_t e;
    e.data = d;
    e.cyc  = f + LAT;
    e.n    = 1;
    if (!stop) e.kind = 1;
    else if (fl) e.kind = 2;
    else begin
      e.kind  = 0;
      last_wr = d;
    end
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_pin = 1'b1; full = 1'b0;
    last_wr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if ({fifo_write_req, fifo_write_data, frame_err, overrun, busy} !== 12'h000) begin
      fails++;
      $display("FAIL reset_state: got req=%b data=%h ferr=%b ovr=%b busy=%b want all 0",
               fifo_write_req, fifo_write_data, frame_err, overrun, busy);
    end
  endtask

  task automatic test_single;
    int f;
    obs.delete(); exp_q.delete();
    idle(10);
    send(8'h55, 1'b1, f);
    model_frame(8'h55, 1'b1, 1'b0, f);
    idle(20);
    tests++;
    if (obs.size() != exp_q.size()) begin
      fails++; $display("FAIL single count: got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      tests++;
      if (obs[i].n !== 1 || obs[i].kind !== exp_q[i].kind || obs[i].cyc !== exp_q[i].cyc ||
          (exp_q[i].kind == 0 && obs[i].data !== exp_q[i].data)) begin
        fails++;
        $display("FAIL single ev%0d: got kind=%0d data=%h cyc=%0d n=%0d want kind=%0d data=%h cyc=%0d",
                 i, obs[i].kind, obs[i].data, obs[i].cyc, obs[i].n, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
    tests++;
    if (fifo_write_data !== last_wr) begin
      fails++; $display("FAIL single data_hold: got %h want %h", fifo_write_data, last_wr);
    end
  endtask

  task automatic test_back_to_back;
    int f1, f2;
    obs.delete(); exp_q.delete();
    idle(10);
    send(8'hA5, 1'b1, f1);
    send(8'h3C, 1'b1, f2);
    model_frame(8'hA5, 1'b1, 1'b0, f1);
    model_frame(8'h3C, 1'b1, 1'b0, f2);
    idle(20);
    tests++;
    if (obs.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b count: got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      tests++;
      if (obs[i].n !== 1 || obs[i].kind !== exp_q[i].kind || obs[i].cyc !== exp_q[i].cyc ||
          (exp_q[i].kind == 0 && obs[i].data !== exp_q[i].data)) begin
        fails++;
        $display("FAIL b2b ev%0d: got kind=%0d data=%h cyc=%0d n=%0d want kind=%0d data=%h cyc=%0d",
                 i, obs[i].kind, obs[i].data, obs[i].cyc, obs[i].n, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
    if (obs.size() >= 2) begin
      tests++;
      if (obs[1].cyc - obs[0].cyc != 10 * C) begin
        fails++; $display("FAIL b2b spacing: got %0d want %0d", obs[1].cyc - obs[0].cyc, 10 * C);
      end
    end
  endtask

  task automatic test_glitch;
    obs.delete(); exp_q.delete();
    idle(10);
    rx_pin = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_pin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL glitch busy_during: got %b want 1", busy);
    end
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL glitch busy_after: got %b want 0", busy);
    end
    idle(20);
    tests++;
    if (obs.size() != 0) begin
      fails++; $display("FAIL glitch count: got %0d want 0", obs.size());
    end
  endtask

  task automatic test_frame_err;
    int f1, f2;
    obs.delete(); exp_q.delete();
    idle(10);
    send(8'h81, 1'b0, f1);
    model_frame(8'h81, 1'b0, 1'b0, f1);
    rx_pin = 1'b0;
    repeat (34) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL ferr busy_break: got %b want 1", busy);
    end
    idle(6);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL ferr busy_released: got %b want 0", busy);
    end
    idle(20);
    send(8'h7E, 1'b1, f2);
    model_frame(8'h7E, 1'b1, 1'b0, f2);
    idle(20);
    tests++;
    if (obs.size() != exp_q.size()) begin
      fails++; $display("FAIL ferr count: got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      tests++;
      if (obs[i].n !== 1 || obs[i].kind !== exp_q[i].kind || obs[i].cyc !== exp_q[i].cyc ||
          (exp_q[i].kind == 0 && obs[i].data !== exp_q[i].data)) begin
        fails++;
        $display("FAIL ferr ev%0d: got kind=%0d data=%h cyc=%0d n=%0d want kind=%0d data=%h cyc=%0d",
                 i, obs[i].kind, obs[i].data, obs[i].cyc, obs[i].n, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_overrun;
    int f1, f2;
    obs.delete(); exp_q.delete();
    full = 1'b1;
    idle(10);
    send(8'h42, 1'b1, f1);
    model_frame(8'h42, 1'b1, 1'b1, f1);
    idle(10);
    full = 1'b0;
    send(8'h42, 1'b1, f2);
    model_frame(8'h42, 1'b1, 1'b0, f2);
    idle(20);
    tests++;
    if (obs.size() != exp_q.size()) begin
      fails++; $display("FAIL overrun count: got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      tests++;
      if (obs[i].n !== 1 || obs[i].kind !== exp_q[i].kind || obs[i].cyc !== exp_q[i].cyc ||
          (exp_q[i].kind == 0 && obs[i].data !== exp_q[i].data)) begin
        fails++;
        $display("FAIL overrun ev%0d: got kind=%0d data=%h cyc=%0d n=%0d want kind=%0d data=%h cyc=%0d",
                 i, obs[i].kind, obs[i].data, obs[i].cyc, obs[i].n, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [9:0] b;
    int         f2;
    obs.delete(); exp_q.delete();
    idle(10);
    b = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_pin = b[i];
      for (int j = 0; j < int'(C); j++) begin
        if (i == 4 && j == 8) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          rst     = 1'b0;
          last_wr = 8'h00;
          tests++;
          if ({fifo_write_req, fifo_write_data, frame_err, overrun, busy} !== 12'h000) begin
            fails++;
            $display("FAIL midreset outputs: got req=%b data=%h ferr=%b ovr=%b busy=%b want all 0",
                     fifo_write_req, fifo_write_data, frame_err, overrun, busy);
          end
        end else begin
          @(posedge clk);
          #1;
        end
      end
    end
    idle(40);
    send(8'h0F, 1'b1, f2);
    model_frame(8'h0F, 1'b1, 1'b0, f2);
    idle(20);
    tests++;
    if (obs.size() != exp_q.size()) begin
      fails++; $display("FAIL midreset count: got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      tests++;
      if (obs[i].n !== 1 || obs[i].kind !== exp_q[i].kind || obs[i].cyc !== exp_q[i].cyc ||
          (exp_q[i].kind == 0 && obs[i].data !== exp_q[i].data)) begin
        fails++;
        $display("FAIL midreset ev%0d: got kind=%0d data=%h cyc=%0d n=%0d want kind=%0d data=%h cyc=%0d",
                 i, obs[i].kind, obs[i].data, obs[i].cyc, obs[i].n, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_random;
    int         f;
    logic [7:0] d;
    logic       fl;
    obs.delete(); exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      fl   = 1'($urandom_range(0, 1));
      full = fl;
      idle(int'($urandom_range(0, 12)));
      d = 8'($urandom);
      send(d, 1'b1, f);
      model_frame(d, 1'b1, fl, f);
    end
    full = 1'b0;
    idle(20);
    tests++;
    if (obs.size() != exp_q.size()) begin
      fails++; $display("FAIL random count: got %0d want %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      tests++;
      if (obs[i].n !== 1 || obs[i].kind !== exp_q[i].kind || obs[i].cyc !== exp_q[i].cyc ||
          (exp_q[i].kind == 0 && obs[i].data !== exp_q[i].data)) begin
        fails++;
        $display("FAIL random ev%0d: got kind=%0d data=%h cyc=%0d n=%0d want kind=%0d data=%h cyc=%0d",
                 i, obs[i].kind, obs[i].data, obs[i].cyc, obs[i].n, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
      end
    end
    tests++;
    if (fifo_write_data !== last_wr) begin
      fails++; $display("FAIL random data_hold: got %h want %h", fifo_write_data, last_wr);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
